// File: rtl/fetch_stage_if.sv
// fetch_stage_if: imem request/response, redirect and decode handshake bundle
interface fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_ins;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  modport master(
    output imem_req_valid, imem_req_addr, id_valid, id_ins, id_pc, id_pc4,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, id_ready
  );
  modport slave(
    input  imem_req_valid, imem_req_addr, id_valid, id_ins, id_pc, id_pc4,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC generation, in-order imem fetch buffer and redirect with wrong-path drop
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic         clk,
  input logic         rst,
  fetch_stage_if.master f
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [AW+1:0] DMAX = (AW+2)'(2*DEPTH-1);
  logic [31:0]    pc;
  logic [AW-1:0]  head, fill, alloc;
  logic [AW:0]    cnt, pend, drop_cnt;
  logic [31:0]    e_pc [DEPTH];
  logic [31:0]    e_ins [DEPTH];
  logic [DEPTH-1:0] e_done;
  logic           fire, rsp_drop, rsp_fill, pop, rd_drop;
  logic [AW+1:0]  drop_sum;
  always_comb begin
    f.imem_req_valid = !rst && !f.redirect_valid && cnt < FULL;
    f.imem_req_addr  = pc;
    fire             = f.imem_req_valid && f.imem_req_ready;
    rsp_drop         = f.imem_resp_valid && drop_cnt != '0;
    rsp_fill         = f.imem_resp_valid && drop_cnt == '0 && pend != '0;
    f.id_valid       = !rst && !f.redirect_valid && cnt != '0 && e_done[head];
    pop              = f.id_valid && f.id_ready;
    f.id_ins         = e_ins[head];
    f.id_pc          = e_pc[head];
    f.id_pc4         = e_pc[head] + 32'd4;
    // a response landing in the redirect cycle is old-path whether or not it was already owed a drop
    rd_drop          = f.imem_resp_valid && (drop_cnt != '0 || pend != '0);
    drop_sum         = {1'b0, drop_cnt} + {1'b0, pend} - {(AW+1)'(0), rd_drop};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      head     <= '0;
      fill     <= '0;
      alloc    <= '0;
      cnt      <= '0;
      pend     <= '0;
      drop_cnt <= '0;
    end else if (f.redirect_valid) begin
      pc       <= {f.redirect_pc[31:2], 2'b00};
      head     <= '0;
      fill     <= '0;
      alloc    <= '0;
      cnt      <= '0;
      pend     <= '0;
      drop_cnt <= drop_sum > DMAX ? DMAX[AW:0] : drop_sum[AW:0];
    end else begin
      if (fire) begin
        e_pc[alloc]   <= pc;
        e_done[alloc] <= 1'b0;
        alloc         <= alloc + AW'(1);
        pc            <= pc + 32'd4;
      end
      if (rsp_fill) begin
        e_ins[fill]  <= f.imem_resp_data;
        e_done[fill] <= 1'b1;
        fill         <= fill + AW'(1);
      end
      if (pop) head <= head + AW'(1);
      cnt      <= cnt + {AW'(0), fire} - {AW'(0), pop};
      pend     <= pend + {AW'(0), fire} - {AW'(0), rsp_fill};
      drop_cnt <= drop_cnt - {AW'(0), rsp_drop};
    end
  end
endmodule
